// File: rtl/prince_pkg.sv
// prince_pkg: phase codes, round-constant indices and latency limits shared by the PRINCE round controller.
package prince_pkg;
   localparam logic [2:0] PH_IDLE = 3'd0;
   localparam logic [2:0] PH_LOAD = 3'd1;
   localparam logic [2:0] PH_FWD  = 3'd2;
   localparam logic [2:0] PH_MID  = 3'd3;
   localparam logic [2:0] PH_BWD  = 3'd4;
   localparam logic [2:0] PH_FIN  = 3'd5;
   localparam logic [2:0] PH_DONE = 3'd6;
   localparam int SEL_LOAD = 2;
   localparam int SEL_FWD0 = 3;
   localparam int SEL_BWD0 = 8;
   localparam int SEL_FIN = 13;
   localparam int NUM_HALF_ROUNDS = 5;
   localparam int ROUND_LAT_MIN = 1;
   localparam int ROUND_LAT_MAX = 8;
   function automatic bit round_lat_ok(input int lat);
      return lat >= ROUND_LAT_MIN && lat <= ROUND_LAT_MAX;
   endfunction
endpackage

// File: rtl/prince_round_cnt.sv
// prince_round_cnt: per-round cycle counter and half-round counter with round/half boundary flags.
module prince_round_cnt
   import prince_pkg::*;
#(
   parameter int ROUND_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       mid,
   output logic [2:0] round,
   output logic       round_end,
   output logic       half_end
);
   localparam int CW = ROUND_LAT > 1 ? $clog2(ROUND_LAT) : 1;
   logic [CW-1:0] cyc;
   assign round_end = en && cyc == CW'(ROUND_LAT - 1);
   assign half_end = round_end && round == 3'(NUM_HALF_ROUNDS - 1);
   // The middle layer is a single round, so its boundary also restarts the round count for BWD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= '0;
         round <= '0;
      end else if (round_end) begin
         cyc <= '0;
         round <= (half_end || mid) ? 3'd0 : round + 3'd1;
      end else if (en) begin
         cyc <= cyc + CW'(1);
      end
   end
endmodule

// File: rtl/prince_round_ctrl.sv
// prince_round_ctrl: round sequencer driving round-constant select, mode and state strobes of the PRINCE core.
module prince_round_ctrl
   import prince_pkg::*;
#(
   parameter int ROUND_LAT = 1,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             enc_dec_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [SEL_W-1:0] sel,
   output logic             enc_dec,
   output logic             load,
   output logic             rnd_en,
   output logic [2:0]       phase,
   output logic             last
);
   if (!round_lat_ok(ROUND_LAT)) begin : g_lat_bad
      $error("prince_round_ctrl: ROUND_LAT out of range");
   end
   logic [2:0] state, state_n;
   logic [2:0] round;
   logic round_end, half_end, cnt_en;
   assign cnt_en = state == PH_FWD || state == PH_MID || state == PH_BWD;
   prince_round_cnt #(.ROUND_LAT(ROUND_LAT)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .en(cnt_en),
      .mid(state == PH_MID),
      .round(round),
      .round_end(round_end),
      .half_end(half_end)
   );
   always_comb begin
      state_n = state;
      case (state)
         PH_IDLE: state_n = start ? PH_LOAD : PH_IDLE;
         PH_LOAD: state_n = PH_FWD;
         PH_FWD:  state_n = half_end ? PH_MID : PH_FWD;
         PH_MID:  state_n = round_end ? PH_BWD : PH_MID;
         PH_BWD:  state_n = half_end ? PH_FIN : PH_BWD;
         PH_FIN:  state_n = PH_DONE;
         default: state_n = PH_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PH_IDLE;
         enc_dec <= 1'b0;
      end else begin
         state <= state_n;
         if (state == PH_IDLE && start) enc_dec <= enc_dec_in;
      end
   end
   // Every output is decoded from registered state; start never reaches an output combinationally.
   assign ready = state == PH_IDLE;
   assign busy = state >= PH_LOAD && state <= PH_FIN;
   assign done = state == PH_DONE;
   assign load = state == PH_LOAD;
   assign last = state == PH_FIN;
   assign phase = state;
   assign rnd_en = load || last || round_end;
   assign sel = load ? SEL_W'(SEL_LOAD) :
                state == PH_FWD ? SEL_W'(SEL_FWD0) + SEL_W'(round) :
                state == PH_BWD ? SEL_W'(SEL_BWD0) + SEL_W'(round) :
                last ? SEL_W'(SEL_FIN) : '0;
endmodule

// File: tb/tb_prince_round_ctrl.sv
// tb_prince_round_ctrl: directed checks of the PRINCE round sequencer at ROUND_LAT=1 and ROUND_LAT=3.
module tb_prince_round_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0, ed1 = 1'b0, start3 = 1'b0, ed3 = 1'b0;
   logic r1, b1, d1, e1, l1, re1, la1;
   logic r3, b3, d3, e3, l3, re3, la3;
   logic [3:0] s1, s3;
   logic [2:0] p1, p3;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prince_round_ctrl #(.ROUND_LAT(1), .SEL_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .enc_dec_in(ed1),
      .ready(r1), .busy(b1), .done(d1), .sel(s1), .enc_dec(e1),
      .load(l1), .rnd_en(re1), .phase(p1), .last(la1)
   );
   prince_round_ctrl #(.ROUND_LAT(3), .SEL_W(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .enc_dec_in(ed3),
      .ready(r3), .busy(b3), .done(d3), .sel(s3), .enc_dec(e3),
      .load(l3), .rnd_en(re3), .phase(p3), .last(la3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected phase/round/cycle k cycles after the accepting IDLE cycle.
   function automatic void exp_at(input int k, input int lat, output logic [2:0] ph, output int rnd, output int cy);
      rnd = 0;
      cy = 0;
      if (k == 1) ph = 3'd1;
      else if (k <= 5 * lat + 1) begin ph = 3'd2; rnd = (k - 2) / lat; cy = (k - 2) % lat; end
      else if (k <= 6 * lat + 1) begin ph = 3'd3; cy = (k - 5 * lat - 2) % lat; end
      else if (k <= 11 * lat + 1) begin ph = 3'd4; rnd = (k - 6 * lat - 2) / lat; cy = (k - 6 * lat - 2) % lat; end
      else if (k == 11 * lat + 2) ph = 3'd5;
      else ph = 3'd6;
   endfunction

   task automatic run_op(input int lat, input logic ed);
      int sel_tab[14] = '{2, 3, 4, 5, 6, 7, 0, 8, 9, 10, 11, 12, 13, 0};
      logic [2:0] ph;
      int rnd, cy, es, ere;
      logic [3:0] s;
      logic r, b, d, e, l, re, la;
      logic [2:0] p;
      if (lat == 1) begin start1 = 1'b1; ed1 = ed; end
      else begin start3 = 1'b1; ed3 = ed; end
      check($sformatf("L%0d ready_pre", lat), lat == 1 ? r1 : r3, 1);
      for (int k = 1; k <= 11 * lat + 3; k++) begin
         @(negedge clk);
         start1 = 1'b0;
         start3 = 1'b0;
         exp_at(k, lat, ph, rnd, cy);
         es = ph == 3'd1 ? 2 : ph == 3'd2 ? 3 + rnd : ph == 3'd4 ? 8 + rnd : ph == 3'd5 ? 13 : 0;
         ere = (ph == 3'd1 || ph == 3'd5 || ((ph == 3'd2 || ph == 3'd3 || ph == 3'd4) && cy == lat - 1)) ? 1 : 0;
         {s, r, b, d, e, l, re, la, p} = lat == 1 ? {s1, r1, b1, d1, e1, l1, re1, la1, p1}
                                                  : {s3, r3, b3, d3, e3, l3, re3, la3, p3};
         check($sformatf("L%0d ed%0d k%0d sel", lat, ed, k), s, es);
         if (lat == 1) check($sformatf("L1 ed%0d k%0d sel_tab", ed, k), s, sel_tab[k-1]);
         check($sformatf("L%0d ed%0d k%0d rnd_en", lat, ed, k), re, ere);
         check($sformatf("L%0d ed%0d k%0d phase", lat, ed, k), p, ph);
         check($sformatf("L%0d ed%0d k%0d done", lat, ed, k), d, k == 11 * lat + 3);
         check($sformatf("L%0d ed%0d k%0d busy", lat, ed, k), b, k <= 11 * lat + 2);
         check($sformatf("L%0d ed%0d k%0d ready", lat, ed, k), r, 0);
         check($sformatf("L%0d ed%0d k%0d load", lat, ed, k), l, k == 1);
         check($sformatf("L%0d ed%0d k%0d last", lat, ed, k), la, k == 11 * lat + 2);
         check($sformatf("L%0d ed%0d k%0d enc_dec", lat, ed, k), e, ed);
      end
      @(negedge clk);
      check($sformatf("L%0d ready_post", lat), lat == 1 ? r1 : r3, 1);
      check($sformatf("L%0d done_post", lat), lat == 1 ? d1 : d3, 0);
   endtask

   initial begin
      int nd;
      int dt[$];
      repeat (3) @(negedge clk);
      check("rst ready", r1, 1);
      check("rst busy", b1, 0);
      check("rst done", d1, 0);
      check("rst sel", s1, 0);
      check("rst enc_dec", e1, 0);
      check("rst load", l1, 0);
      check("rst rnd_en", re1, 0);
      check("rst phase", p1, 0);
      check("rst last", la1, 0);
      check("rst ready3", r3, 1);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(1, 1'b0);
      run_op(1, 1'b1);
      run_op(3, 1'b0);
      // start during FWD and during DONE is ignored; the following IDLE accepts
      start1 = 1'b1; ed1 = 1'b0;
      @(negedge clk); start1 = 1'b0;
      repeat (2) @(negedge clk);
      start1 = 1'b1; ed1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      check("ovl fwd phase", p1, 3'd2);
      check("ovl fwd enc_dec", e1, 0);
      repeat (10) @(negedge clk);
      check("ovl done", d1, 1);
      start1 = 1'b1; ed1 = 1'b1;
      @(negedge clk);
      check("ovl idle ready", r1, 1);
      check("ovl idle phase", p1, 3'd0);
      check("ovl idle enc_dec", e1, 0);
      @(negedge clk); start1 = 1'b0;
      check("ovl relaunch phase", p1, 3'd1);
      check("ovl relaunch enc_dec", e1, 1);
      for (int i = 0; i < 40 && !d1; i++) @(negedge clk);
      check("ovl relaunch done", d1, 1);
      @(negedge clk);
      // asynchronous abort in BWD round 2
      start1 = 1'b1; ed1 = 1'b0;
      @(negedge clk); start1 = 1'b0;
      repeat (9) @(negedge clk);
      check("abort pre sel", s1, 10);
      rst_n = 1'b0;
      #1;
      check("abort ready", r1, 1);
      check("abort sel", s1, 0);
      check("abort busy", b1, 0);
      check("abort phase", p1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (d1) nd++;
      end
      check("abort no done", nd, 0);
      run_op(1, 1'b0);
      // start held high: operations back to back every 15 cycles
      start1 = 1'b1; ed1 = 1'b0;
      for (int t = 1; t <= 45; t++) begin
         @(negedge clk);
         if (d1) dt.push_back(t);
      end
      start1 = 1'b0;
      check("b2b count", dt.size(), 3);
      if (dt.size() == 3) begin
         check("b2b first", dt[0], 14);
         check("b2b gap1", dt[1] - dt[0], 15);
         check("b2b gap2", dt[2] - dt[1], 15);
      end
      check("b2b idle", r1, 1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
